uart_send_ctrl: RTL and testbench
=================================

# uart_send_ctrl

Multi-channel send controller for the UART subsystem. It decodes the send opcode from the CPU and turns each send instruction into exactly one single-cycle start strobe on the selected UART transmit channel. It waits for that channel to be ready, then holds the CPU stalled for a programmable hold window. It sits between the CPU decode stage and N UART transmitters, and reports illegal-channel and overrun errors.

## Interface
Parameters:
- OPCODE_W, 6, opcode width
- OPCODE_SND, 6'b010001, send opcode value
- CHANNELS, 2, number of TX channels (1..16)
- CH_W, $clog2(CHANNELS) (min 1), channel-select width
- HOLD_CYCLES, 4, cycles of stall after the strobe (>=1)

Ports (single clock domain; reset asynchronous, active-low):
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  current instruction opcode
- req_valid  in  1  instruction valid in decode
- chan_sel  in  CH_W  target channel for this send
- tx_ready  in  CHANNELS  per-channel transmitter idle
- err_clr  in  1  clears sticky error flags
- snd_flag  out  CHANNELS  one-hot, one-cycle start strobe
- snd_extend  out  1  CPU stall request
- busy  out  1  state != IDLE
- err_chan  out  1  sticky: chan_sel >= CHANNELS on accept
- err_overrun  out  1  sticky: send request dropped

## Operation
- is_snd = req_valid & (opcode == OPCODE_SND). A request is a rising edge: is_snd & ~is_snd_q, where is_snd_q is registered. is_snd held high for many cycles yields one request.
- FSM states: IDLE, WAIT_READY, FIRE, HOLD.
- IDLE + request + legal channel: latch ch_q <= chan_sel and go to WAIT_READY.
- IDLE + request + illegal channel: set err_chan and stay in IDLE. No strobe is issued.
- WAIT_READY: stays until tx_ready[ch_q] = 1, then goes to FIRE. There is no timeout.
- FIRE: snd_flag[ch_q] = 1 for this one cycle only. Load hold counter with HOLD_CYCLES-1, then go to HOLD.
- HOLD: counter decrements each cycle. At 0 it exits to IDLE, or to the pending request when the queue is enabled.
- snd_extend = (state != IDLE) | (request accepted in IDLE). The second term is combinational, so the stall begins in the request cycle.
- Request while state != IDLE, with no queue or a full queue: the request is dropped and err_overrun is set.
- err_clr clears both sticky flags. A new set event in the same cycle wins over err_clr.

## Timing
- Reset values: state IDLE, snd_flag 0, snd_extend 0, busy 0, both error flags 0, is_snd_q 0, queue empty. Reset mid-operation drops any strobe immediately (asynchronous).
- Latency: request in cycle N; WAIT_READY in N+1; with tx_ready high in N+1, snd_flag is high in N+2.
- Stall length with tx_ready already high: 2 + HOLD_CYCLES cycles (N through N+1+HOLD_CYCLES). IDLE is reached at N+2+HOLD_CYCLES.
- tx_ready is sampled only in WAIT_READY. A change during HOLD has no effect.

## Configuration
- SEND_CTRL_QUEUE_EN defined: a one-entry pending slot holding a channel and a valid bit.
  - A legal request arriving while busy is stored in the slot.
  - When HOLD ends with the slot valid, the FSM goes directly to WAIT_READY with ch_q <= slot, with no IDLE cycle.
  - If a new request arrives in the same cycle the slot is popped, it refills the slot with no overrun.
  - A request arriving while the slot is already full sets err_overrun.
  - snd_extend stays high while the slot is valid.
  - An illegal channel is never queued; it sets err_chan.
- SEND_CTRL_QUEUE_EN undefined: no slot. Every request while busy is dropped and sets err_overrun.

## Structure
- Package uart_pkg: state enum (IDLE, WAIT_READY, FIRE, HOLD), OPCODE_SND default, opcode width constant.
- Sub-module snd_hold_timer: loadable down-counter of width $clog2(HOLD_CYCLES+1), with a done output. It is reset by reset_n.

## Test plan
- Single send: CHANNELS=2, HOLD_CYCLES=4, tx_ready=2'b11, chan_sel=1, is_snd high for 5 cycles -> exactly one snd_flag=2'b10 at N+2; snd_extend high N..N+5; busy low at N+6.
- Ready wait: tx_ready[0]=0 for 7 cycles after the request -> the FSM stays in WAIT_READY and snd_extend holds; the strobe occurs 1 cycle after tx_ready[0] rises.
- Illegal channel: CHANNELS=3, chan_sel=3 -> no strobe, err_chan=1, busy stays 0; err_clr pulse -> err_chan=0.
- Overrun, macro off: second rising edge during HOLD -> ignored, err_overrun=1, only one strobe.
- Queue, macro on: edges for ch0 then ch1 during HOLD -> strobes ch0 then ch1 with no IDLE cycle between them; a third edge while the slot is full -> err_overrun=1.
- Reset mid-HOLD: reset_n low -> all outputs 0 immediately; after release, a request works normally.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART send controller:
//   - UART_OPCODE_W   : width of the CPU opcode field
//   - UART_OPCODE_SND : default encoding of the send instruction
//   - snd_state_e     : send-controller FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_OPCODE_W = 6;
  localparam logic [UART_OPCODE_W-1:0] UART_OPCODE_SND = 6'b010001;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_READY,
    FIRE,
    HOLD
  } snd_state_e;

endpackage

// File: rtl/snd_hold_timer.sv
// ---------------------------------------------------------------------------
// snd_hold_timer
// Loadable down-counter that times the CPU stall window after a send strobe.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   i_load     in   load i_load_val into the counter
//   i_load_val in   value loaded on i_load
//   i_dec      in   decrement by one (saturates at zero)
//   o_done     out  the decrement taken this cycle brings the count to zero
// ---------------------------------------------------------------------------
module snd_hold_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Done is flagged one cycle early so the FSM can leave HOLD on the same
  // edge where the count reaches zero.
  assign o_done = (r_cnt == '0) || (r_cnt == CNT_W'(1));

endmodule

// File: rtl/uart_send_ctrl.sv
// ---------------------------------------------------------------------------
// uart_send_ctrl
// Turns each rising edge of a decoded send instruction into exactly one
// single-cycle start strobe on the selected UART TX channel, waiting for the
// channel to be ready and stalling the CPU for a programmable hold window.
//
// Optional feature: define SEND_CTRL_QUEUE_EN to add a one-entry pending slot
// that accepts one legal request while the controller is busy.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   opcode      in   current instruction opcode
//   req_valid   in   instruction valid in decode
//   chan_sel    in   target channel for this send
//   tx_ready    in   per-channel transmitter idle
//   err_clr     in   clears sticky error flags
//   snd_flag    out  one-hot, one-cycle start strobe
//   snd_extend  out  CPU stall request
//   busy        out  FSM not idle
//   err_chan    out  sticky: illegal channel requested
//   err_overrun out  sticky: send request dropped
// ---------------------------------------------------------------------------
module uart_send_ctrl
  import uart_pkg::*;
#(
  parameter int                  OPCODE_W    = UART_OPCODE_W,
  parameter logic [OPCODE_W-1:0] OPCODE_SND  = UART_OPCODE_SND,
  parameter int                  CHANNELS    = 2,
  parameter int                  CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int                  HOLD_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                req_valid,
  input  logic [CH_W-1:0]     chan_sel,
  input  logic [CHANNELS-1:0] tx_ready,
  input  logic                err_clr,
  output logic [CHANNELS-1:0] snd_flag,
  output logic                snd_extend,
  output logic                busy,
  output logic                err_chan,
  output logic                err_overrun
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  snd_state_e      r_state;
  snd_state_e      w_state_nxt;
  logic [CH_W-1:0] r_ch_q;
  logic [CH_W-1:0] w_ch_nxt;
  logic            r_is_snd_q;
  logic            r_err_chan;
  logic            r_err_overrun;

  logic            w_is_snd;
  logic            w_req;
  logic            w_legal;
  logic            w_busy;
  logic            w_exit;
  logic            w_tmr_load;
  logic            w_tmr_dec;
  logic            w_tmr_done;
  logic            w_slot_v;
  logic            w_pend_v;
  logic [CH_W-1:0] w_pend_ch;
  logic            w_set_chan;
  logic            w_set_overrun;

  // A send is recognised only on the rising edge of the decoded instruction,
  // so an opcode held in decode for several cycles issues a single request.
  assign w_is_snd = req_valid & (opcode == OPCODE_SND);
  assign w_req    = w_is_snd & ~r_is_snd_q;
  assign w_legal  = (32'(chan_sel) < CHANNELS);
  assign w_busy   = (r_state != IDLE);

  snd_hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (w_tmr_load),
    .i_load_val(CNT_W'(HOLD_CYCLES - 1)),
    .i_dec     (w_tmr_dec),
    .o_done    (w_tmr_done)
  );

  // State, latched channel and the edge-detect history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ch_q     <= '0;
      r_is_snd_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ch_q     <= w_ch_nxt;
      r_is_snd_q <= w_is_snd;
    end
  end

  // Next-state logic. Leaving the stall window either returns to IDLE or,
  // when a request is pending, goes straight back to WAIT_READY.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch_q;
    w_tmr_load  = 1'b0;
    w_tmr_dec   = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && w_legal) begin
          w_state_nxt = WAIT_READY;
          w_ch_nxt    = chan_sel;
        end
      end
      WAIT_READY: begin
        if (tx_ready[r_ch_q]) begin
          w_state_nxt = FIRE;
        end
      end
      FIRE: begin
        w_tmr_load = 1'b1;
        if (HOLD_CYCLES == 1) begin
          w_exit = 1'b1;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_tmr_dec = 1'b1;
        if (w_tmr_done) begin
          w_exit = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_exit) begin
      if (w_pend_v) begin
        w_state_nxt = WAIT_READY;
        w_ch_nxt    = w_pend_ch;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

`ifdef SEND_CTRL_QUEUE_EN
  logic            r_slot_v;
  logic [CH_W-1:0] r_slot_ch;
  logic            w_busy_legal_req;

  assign w_busy_legal_req = w_req & w_legal & w_busy;

  // One-entry pending slot. On the pop cycle a simultaneous new request
  // refills it; a request arriving at exit with the slot empty bypasses it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_v  <= 1'b0;
      r_slot_ch <= '0;
    end else if (w_exit) begin
      r_slot_v <= r_slot_v & w_busy_legal_req;
      if (w_busy_legal_req) begin
        r_slot_ch <= chan_sel;
      end
    end else if (w_busy_legal_req && !r_slot_v) begin
      r_slot_v  <= 1'b1;
      r_slot_ch <= chan_sel;
    end
  end

  assign w_slot_v      = r_slot_v;
  assign w_pend_v      = r_slot_v | w_busy_legal_req;
  assign w_pend_ch     = r_slot_v ? r_slot_ch : chan_sel;
  assign w_set_chan    = w_req & ~w_legal;
  assign w_set_overrun = w_busy_legal_req & r_slot_v & ~w_exit;
`else
  assign w_slot_v      = 1'b0;
  assign w_pend_v      = 1'b0;
  assign w_pend_ch     = r_ch_q;
  assign w_set_chan    = w_req & ~w_legal & ~w_busy;
  assign w_set_overrun = w_req & w_busy;
`endif

  // Sticky error flags: a new set event wins over a same-cycle clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_chan    <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_set_chan) begin
        r_err_chan <= 1'b1;
      end else if (err_clr) begin
        r_err_chan <= 1'b0;
      end
      if (w_set_overrun) begin
        r_err_overrun <= 1'b1;
      end else if (err_clr) begin
        r_err_overrun <= 1'b0;
      end
    end
  end

  // Strobe decoded from state so an asynchronous reset removes it at once.
  always_comb begin
    snd_flag = '0;
    if (r_state == FIRE) begin
      snd_flag[r_ch_q] = 1'b1;
    end
  end

  // The accept term is combinational so the stall starts in the request cycle.
  assign snd_extend  = w_busy | (w_req & w_legal) | w_slot_v;
  assign busy        = w_busy;
  assign err_chan    = r_err_chan;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_send_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_send_ctrl
// Self-checking bench for uart_send_ctrl (CHANNELS=3, HOLD_CYCLES=4).
// A timestamp-based job model predicts all outputs every cycle; directed
// sequences add literal expectations. Queue tests build with
// SEND_CTRL_QUEUE_EN, overrun-drop tests without it.
// ---------------------------------------------------------------------------
module tb_uart_send_ctrl;
  import uart_pkg::*;

  localparam int CHANNELS    = 3;
  localparam int CH_W        = 2;
  localparam int HOLD_CYCLES = 4;
  localparam logic [5:0] SND = UART_OPCODE_SND;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [5:0]          opcode = '0;
  logic                req_valid = 1'b0;
  logic [CH_W-1:0]     chan_sel = '0;
  logic [CHANNELS-1:0] tx_ready = '1;
  logic                err_clr = 1'b0;
  logic [CHANNELS-1:0] snd_flag;
  logic                snd_extend;
  logic                busy;
  logic                err_chan;
  logic                err_overrun;

  int testsRun = 0;
  int testsFailed = 0;
  int strobeCount = 0;
  int cyc = 0;
  int sc0;

  // Model state: the active job is described by timestamps, not states.
  bit mActive;
  int mCh;
  int mFireAt;
  int mDoneAt;
  bit mPendV;
  int mPendCh;
  bit mPrevSnd;
  bit mErrC;
  bit mErrO;

  uart_send_ctrl #(
    .OPCODE_W(6), .OPCODE_SND(SND), .CHANNELS(CHANNELS), .CH_W(CH_W),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .req_valid(req_valid),
    .chan_sel(chan_sel), .tx_ready(tx_ready), .err_clr(err_clr),
    .snd_flag(snd_flag), .snd_extend(snd_extend), .busy(busy),
    .err_chan(err_chan), .err_overrun(err_overrun)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op, input int ch,
                               input logic [CHANNELS-1:0] rdy, input logic clr);
    req_valid = v;
    opcode    = op;
    chan_sel  = CH_W'(ch);
    tx_ready  = rdy;
    err_clr   = clr;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clock);
  endtask

  task automatic startJob(input int ch);
    mActive = 1'b1;
    mCh     = ch;
    mFireAt = -1;
    mDoneAt = -1;
  endtask

  // Model + compare: outputs of the current cycle are checked, then the
  // model advances across the coming rising edge.
  always @(negedge clock) begin
    bit isSnd, req, legal, finishing, setC, setO;
    logic [CHANNELS-1:0] expFlag;
    cyc++;
    if (!reset_n) begin
      mActive = 0; mPendV = 0; mPrevSnd = 0; mErrC = 0; mErrO = 0;
      mFireAt = -1; mDoneAt = -1;
    end else begin
      isSnd   = req_valid && (opcode == SND);
      req     = isSnd && !mPrevSnd;
      legal   = (int'(chan_sel) < CHANNELS);
      expFlag = (mActive && cyc == mFireAt) ? CHANNELS'(1 << mCh) : '0;
      if (snd_flag != '0) strobeCount++;
      checkOutput("model snd_flag", snd_flag, expFlag);
      checkOutput("model snd_extend", snd_extend, mActive || (!mActive && req && legal) || mPendV);
      checkOutput("model busy", busy, mActive);
      checkOutput("model err_chan", err_chan, mErrC);
      checkOutput("model err_overrun", err_overrun, mErrO);

      setC = 0;
      setO = 0;
      finishing = mActive && (mFireAt >= 0) && (cyc + 1 == mDoneAt);
      if (mActive && mFireAt < 0 && tx_ready[mCh]) begin
        mFireAt = cyc + 1;
        mDoneAt = cyc + 1 + HOLD_CYCLES;
      end
      if (!mActive) begin
        if (req && legal) startJob(int'(chan_sel));
        else if (req) setC = 1;
      end else begin
`ifdef SEND_CTRL_QUEUE_EN
        if (req && !legal) setC = 1;
        else if (req && mPendV && !finishing) setO = 1;
        if (finishing) begin
          if (mPendV) begin
            startJob(mPendCh);
            mPendV  = req && legal;
            mPendCh = int'(chan_sel);
          end else if (req && legal) begin
            startJob(int'(chan_sel));
          end else begin
            mActive = 0;
          end
        end else if (req && legal && !mPendV) begin
          mPendV  = 1;
          mPendCh = int'(chan_sel);
        end
`else
        if (req) setO = 1;
        if (finishing) mActive = 0;
`endif
      end
      if (setC) mErrC = 1; else if (err_clr) mErrC = 0;
      if (setO) mErrO = 1; else if (err_clr) mErrO = 0;
      mPrevSnd = isSnd;
    end
  end

  initial begin
    // Reset state
    applyStimulus(0, 6'd0, 0, 3'b111, 0);
    repeat (3) nextCycle();
    midCycle();
    checkOutput("reset snd_flag", snd_flag, 0);
    checkOutput("reset snd_extend", snd_extend, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset err_chan", err_chan, 0);
    checkOutput("reset err_overrun", err_overrun, 0);
    nextCycle();
    reset_n = 1'b1;
    nextCycle();

    // Single send on ch1, opcode held for 5 cycles
    sc0 = strobeCount;
    applyStimulus(1, SND, 1, 3'b111, 0);
    midCycle(); checkOutput("single ext N", snd_extend, 1); checkOutput("single busy N", busy, 0);
    nextCycle();
    midCycle(); checkOutput("single busy N+1", busy, 1); checkOutput("single flag N+1", snd_flag, 0);
    nextCycle();
    midCycle(); checkOutput("single flag N+2", snd_flag, 3'b010);
    nextCycle();
    nextCycle();
    nextCycle();
    applyStimulus(0, SND, 1, 3'b111, 0);
    midCycle(); checkOutput("single ext N+5", snd_extend, 1);
    nextCycle();
    midCycle(); checkOutput("single busy N+6", busy, 0); checkOutput("single ext N+6", snd_extend, 0);
    nextCycle();
    checkOutput("single strobe count", strobeCount - sc0, 1);

    // Non-send opcode is ignored
    applyStimulus(1, 6'b010000, 0, 3'b111, 0);
    midCycle(); checkOutput("wrong op ext", snd_extend, 0);
    nextCycle();
    midCycle(); checkOutput("wrong op busy", busy, 0);
    applyStimulus(0, 6'd0, 0, 3'b111, 0);
    nextCycle();

    // Ready wait on ch0, tx_ready[0] low for 7 cycles
    applyStimulus(1, SND, 0, 3'b110, 0);
    nextCycle();
    applyStimulus(0, SND, 0, 3'b110, 0);
    repeat (4) nextCycle();
    midCycle();
    checkOutput("wait busy", busy, 1);
    checkOutput("wait ext", snd_extend, 1);
    checkOutput("wait flag", snd_flag, 0);
    repeat (3) nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 0);
    midCycle(); checkOutput("wait flag at ready", snd_flag, 0);
    nextCycle();
    midCycle(); checkOutput("wait strobe", snd_flag, 3'b001);
    nextCycle();
    applyStimulus(0, SND, 0, 3'b000, 0);
    repeat (3) nextCycle();
    midCycle(); checkOutput("wait idle", busy, 0);
    applyStimulus(0, SND, 0, 3'b111, 0);
    nextCycle();

    // Illegal channel, then set-over-clear priority, then clear
    applyStimulus(1, SND, 3, 3'b111, 0);
    midCycle(); checkOutput("illegal ext", snd_extend, 0);
    nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 0);
    midCycle();
    checkOutput("illegal err_chan", err_chan, 1);
    checkOutput("illegal busy", busy, 0);
    nextCycle();
    applyStimulus(1, SND, 3, 3'b111, 1);
    nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 0);
    midCycle(); checkOutput("set beats clr", err_chan, 1);
    nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 1);
    nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 0);
    midCycle(); checkOutput("err_chan cleared", err_chan, 0);
    nextCycle();

`ifdef SEND_CTRL_QUEUE_EN
    // Queue: ch0, then ch1 queued, then ch2 with slot full
    sc0 = strobeCount;
    applyStimulus(1, SND, 0, 3'b111, 0); nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 0); nextCycle();
    applyStimulus(1, SND, 1, 3'b111, 0);
    midCycle(); checkOutput("queue flag ch0", snd_flag, 3'b001);
    nextCycle();
    applyStimulus(0, SND, 1, 3'b111, 0); nextCycle();
    applyStimulus(1, SND, 2, 3'b111, 0); nextCycle();
    applyStimulus(0, SND, 2, 3'b111, 0);
    midCycle();
    checkOutput("queue overrun", err_overrun, 1);
    checkOutput("queue ext", snd_extend, 1);
    nextCycle();
    midCycle(); checkOutput("queue no idle", busy, 1);
    nextCycle();
    midCycle(); checkOutput("queue flag ch1", snd_flag, 3'b010);
    repeat (4) nextCycle();
    midCycle(); checkOutput("queue idle", busy, 0);
    nextCycle();
    checkOutput("queue strobe count", strobeCount - sc0, 2);
`else
    // Overrun: second edge during HOLD is dropped
    sc0 = strobeCount;
    applyStimulus(1, SND, 2, 3'b111, 0); nextCycle();
    applyStimulus(0, SND, 2, 3'b111, 0); nextCycle();
    nextCycle();
    applyStimulus(1, SND, 0, 3'b111, 0); nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 0);
    midCycle(); checkOutput("overrun flag", err_overrun, 1);
    nextCycle();
    nextCycle();
    midCycle(); checkOutput("overrun idle", busy, 0);
    nextCycle();
    checkOutput("overrun strobe count", strobeCount - sc0, 1);
`endif
    applyStimulus(0, SND, 0, 3'b111, 1);
    nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 0);
    midCycle(); checkOutput("err_overrun cleared", err_overrun, 0);
    nextCycle();

    // Reset during the strobe cycle
    applyStimulus(1, SND, 3, 3'b111, 0); nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 0); nextCycle();
    applyStimulus(1, SND, 1, 3'b111, 0); nextCycle();
    applyStimulus(0, SND, 1, 3'b111, 0); nextCycle();
    #1;
    checkOutput("pre-reset strobe", snd_flag, 3'b010);
    checkOutput("pre-reset err_chan", err_chan, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset flag", snd_flag, 0);
    checkOutput("async reset ext", snd_extend, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset err_chan", err_chan, 0);
    nextCycle();
    reset_n = 1'b1;
    nextCycle();
    applyStimulus(1, SND, 0, 3'b111, 0); nextCycle();
    applyStimulus(0, SND, 0, 3'b111, 0); nextCycle();
    midCycle(); checkOutput("post-reset strobe", snd_flag, 3'b001);
    repeat (5) nextCycle();
    midCycle(); checkOutput("post-reset idle", busy, 0);
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
